// File: rtl/pci_target_ctrl.sv
// Control FSM for a partial PCI target: decodes memory read/write hits on an
// 8 x 32-bit window, drives the target handshakes and sequences the datapath.
module pci_target_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned MAX_WAIT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        req64_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_addr,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic        ack64_n,
  output logic [2:0]  add1,
  output logic [2:0]  add2,
  output logic        we1,
  output logic        we2,
  output logic        oe,
  output logic        mode,
  output logic        par_e1,
  output logic        par_e2,
  output logic        perr_e1,
  output logic        perr_e2
);

  typedef enum logic [2:0] {IDLE, DEV, XFER, DISC, TAR} state_t;

  localparam int unsigned CW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_PRE = CW'(MAX_WAIT - 2);

  state_t        state;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic          wide;
  logic          is_wr;
  logic [CW-1:0] wait_cnt;
  logic          hit;
  logic          cmd_ok;
  logic          xfer_now;
  logic          unused;

  assign unused   = ^ad_addr[1:0];
  assign hit      = (ad_addr[31:5] == BASE_ADDR[31:5]);
  assign cmd_ok   = (cbe_n == 4'b0110) || (cbe_n == 4'b0111);
  assign xfer_now = (state == XFER) && !irdy_n && !trdy_n;
  assign idx_next = idx + (wide ? 3'd2 : 3'd1);

  assign add1 = idx;
  assign add2 = idx + 3'd1;
  assign we1  = is_wr && (state == XFER) && !irdy_n;
  assign we2  = we1 && wide;

  // A phase is the last one before the window wraps past word 7.
  function automatic logic is_last(input logic [2:0] i, input logic w);
    return w ? (i >= 3'd6) : (i == 3'd7);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      devsel_n <= 1'b1;
      trdy_n   <= 1'b1;
      stop_n   <= 1'b1;
      ack64_n  <= 1'b1;
      idx      <= '0;
      wide     <= 1'b0;
      is_wr    <= 1'b0;
      oe       <= 1'b0;
      mode     <= 1'b1;
      wait_cnt <= '0;
      par_e1   <= 1'b0;
      par_e2   <= 1'b0;
      perr_e1  <= 1'b0;
      perr_e2  <= 1'b0;
    end else begin
      par_e1  <= xfer_now && !is_wr;
      par_e2  <= xfer_now && !is_wr && wide;
      perr_e1 <= xfer_now && is_wr;
      perr_e2 <= xfer_now && is_wr && wide;

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (!frame_n && hit && cmd_ok) begin
            idx      <= ad_addr[4:2];
            is_wr    <= cbe_n[0];
            wide     <= !req64_n;
            devsel_n <= 1'b0;
            ack64_n  <= req64_n;
            oe       <= !cbe_n[0];
            mode     <= req64_n;
            state    <= DEV;
          end
        end
        DEV: begin
          trdy_n <= 1'b0;
          stop_n <= !is_last(idx, wide);
          state  <= XFER;
        end
        XFER: begin
          if (xfer_now) begin
            idx      <= idx_next;
            wait_cnt <= '0;
            if (frame_n) begin
              devsel_n <= 1'b1;
              trdy_n   <= 1'b1;
              stop_n   <= 1'b1;
              ack64_n  <= 1'b1;
              oe       <= 1'b0;
              state    <= TAR;
            end else if (!stop_n) begin
              trdy_n <= 1'b1;
              state  <= DISC;
            end else begin
              stop_n <= !is_last(idx_next, wide);
            end
          end else if (wait_cnt == WAIT_PRE) begin
            // counter would reach MAX_WAIT-1: retry without moving data
            trdy_n <= 1'b1;
            stop_n <= 1'b0;
            state  <= DISC;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DISC: begin
          if (frame_n) begin
            devsel_n <= 1'b1;
            trdy_n   <= 1'b1;
            stop_n   <= 1'b1;
            ack64_n  <= 1'b1;
            oe       <= 1'b0;
            state    <= TAR;
          end
        end
        TAR: begin
          mode  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Bench for pci_target_ctrl: table of per-cycle inputs and expected outputs,
// plus hand-written sequences for wait timeout and mid-transaction reset.
module tb_pci_target_ctrl;

  localparam int unsigned MAX_WAIT = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [3:0] RD = 4'b0110;
  localparam logic [3:0] WR = 4'b0111;
  localparam logic [3:0] NC = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_n, irdy_n, req64_n;
  logic [3:0]  cbe_n;
  logic [31:0] ad_addr;
  logic        devsel_n, trdy_n, stop_n, ack64_n;
  logic [2:0]  add1, add2;
  logic        we1, we2, oe, mode, par_e1, par_e2, perr_e1, perr_e2;
  logic [17:0] act;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        fr;
    logic        ir;
    logic        r64;
    logic [3:0]  cbe;
    logic [31:0] addr;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  pci_target_ctrl #(.BASE_ADDR(32'h0000_1000), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .req64_n(req64_n),
    .cbe_n(cbe_n), .ad_addr(ad_addr), .devsel_n(devsel_n), .trdy_n(trdy_n),
    .stop_n(stop_n), .ack64_n(ack64_n), .add1(add1), .add2(add2), .we1(we1),
    .we2(we2), .oe(oe), .mode(mode), .par_e1(par_e1), .par_e2(par_e2),
    .perr_e1(perr_e1), .perr_e2(perr_e2)
  );

  always #5 clk = ~clk;

  assign act = {devsel_n, trdy_n, stop_n, ack64_n, add1, add2,
                we1, we2, oe, mode, par_e1, par_e2, perr_e1, perr_e2};

  function automatic logic [17:0] pk(input logic d, input logic t, input logic s,
                                     input logic a, input logic [2:0] a1,
                                     input logic w1, input logic w2, input logic o,
                                     input logic m, input logic p1, input logic p2,
                                     input logic q1, input logic q2);
    logic [2:0] a2;
    a2 = a1 + 3'd1;
    return {d, t, s, a, a1, a2, w1, w2, o, m, p1, p2, q1, q2};
  endfunction

  function automatic logic [17:0] quiet(input logic [2:0] a1);
    return pk(H, H, H, H, a1, L, L, L, H, L, L, L, L);
  endfunction

  function automatic void add(input logic fr, input logic ir, input logic r64,
                              input logic [3:0] cbe, input logic [31:0] addr,
                              input logic [17:0] exp);
    vec_t v;
    v.fr = fr; v.ir = ir; v.r64 = r64; v.cbe = cbe; v.addr = addr; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, n, got, want);
    end
  endtask

  task automatic drive(input logic fr, input logic ir, input logic r64,
                       input logic [3:0] cbe, input logic [31:0] addr);
    frame_n = fr; irdy_n = ir; req64_n = r64; cbe_n = cbe; ad_addr = addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfer_cycles;
    int stop_at;
    logic saw_we;

    // 32-bit single write at 0x1008 (index 2), frame_n rises during DEV
    add(L, H, H, WR, 32'h1008, quiet(3'd0));
    add(H, L, H, NC, 32'h0,    pk(L, H, H, H, 3'd2, L, L, L, H, L, L, L, L));
    add(H, L, H, NC, 32'h0,    pk(L, L, H, H, 3'd2, H, L, L, H, L, L, L, L));
    add(H, H, H, NC, 32'h0,    pk(H, H, H, H, 3'd3, L, L, L, H, L, L, H, L));
    add(H, H, H, NC, 32'h0,    quiet(3'd3));
    // 64-bit read burst at 0x1000, two phases
    add(L, H, L, RD, 32'h1000, quiet(3'd3));
    add(L, L, H, NC, 32'h0,    pk(L, H, H, L, 3'd0, L, L, H, L, L, L, L, L));
    add(L, L, H, NC, 32'h0,    pk(L, L, H, L, 3'd0, L, L, H, L, L, L, L, L));
    add(H, L, H, NC, 32'h0,    pk(L, L, H, L, 3'd2, L, L, H, L, H, H, L, L));
    add(H, H, H, NC, 32'h0,    pk(H, H, H, H, 3'd4, L, L, L, L, H, H, L, L));
    add(H, H, H, NC, 32'h0,    quiet(3'd4));
    // 32-bit write burst from 0x1018: disconnect on word 7, no third write
    add(L, H, H, WR, 32'h1018, quiet(3'd4));
    add(L, L, H, NC, 32'h0,    pk(L, H, H, H, 3'd6, L, L, L, H, L, L, L, L));
    add(L, L, H, NC, 32'h0,    pk(L, L, H, H, 3'd6, H, L, L, H, L, L, L, L));
    add(L, L, H, NC, 32'h0,    pk(L, L, L, H, 3'd7, H, L, L, H, L, L, H, L));
    add(L, L, H, NC, 32'h0,    pk(L, H, L, H, 3'd0, L, L, L, H, L, L, H, L));
    add(H, L, H, NC, 32'h0,    pk(L, H, L, H, 3'd0, L, L, L, H, L, L, L, L));
    add(H, H, H, NC, 32'h0,    quiet(3'd0));
    add(H, H, H, NC, 32'h0,    quiet(3'd0));
    // address miss, then unsupported command
    add(L, H, H, WR, 32'h2000, quiet(3'd0));
    add(L, L, H, NC, 32'h0,    quiet(3'd0));
    add(H, H, H, NC, 32'h0,    quiet(3'd0));
    add(L, H, H, 4'b0010, 32'h1000, quiet(3'd0));
    add(L, L, H, NC, 32'h0,    quiet(3'd0));
    add(H, H, H, NC, 32'h0,    quiet(3'd0));

    rst = 1'b1;
    drive(H, H, H, NC, 32'h0);
    @(negedge clk); #1;
    chk("reset", 0, 32'(act), 32'(quiet(3'd0)));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fr, vecs[i].ir, vecs[i].r64, vecs[i].cbe, vecs[i].addr);
      #1;
      chk("vec", i, 32'(act), 32'(vecs[i].exp));
    end

    // Wait timeout: 32-bit read at 0x1004 with irdy_n never asserted
    @(negedge clk); drive(L, H, H, RD, 32'h1004);
    @(negedge clk); drive(L, H, H, NC, 32'h0);
    xfer_cycles = 0;
    stop_at = -1;
    saw_we = 1'b0;
    for (int k = 0; k < 40 && stop_at < 0; k++) begin
      @(negedge clk); #1;
      if (!trdy_n) xfer_cycles++;
      if (we1) saw_we = 1'b1;
      if (!stop_n) begin
        stop_at = xfer_cycles;
        chk("timeout_trdy", 0, 32'(trdy_n), 32'(H));
        chk("timeout_devsel", 0, 32'(devsel_n), 32'(L));
        frame_n = 1'b1;
      end
    end
    chk("timeout_cycles", 0, 32'(xfer_cycles), 32'(MAX_WAIT - 1));
    chk("timeout_stop_at", 0, 32'(stop_at), 32'(MAX_WAIT - 1));
    chk("timeout_no_we", 0, 32'(saw_we), 32'(L));
    @(negedge clk); #1;
    chk("timeout_tar", 0, 32'(act), 32'(quiet(3'd1)));

    // Reset asserted mid-XFER of a 64-bit write at 0x1010
    @(negedge clk); drive(L, H, L, WR, 32'h1010);
    @(negedge clk); drive(L, L, H, NC, 32'h0);
    @(negedge clk); #1;
    chk("rst_pre", 0, 32'(act), 32'(pk(L, L, H, L, 3'd4, H, H, L, L, L, L, L, L)));
    #1 rst = 1'b1;
    #1 chk("rst_async", 0, 32'(act), 32'(quiet(3'd0)));
    @(negedge clk);
    rst = 1'b0;
    drive(H, H, H, NC, 32'h0);
    @(negedge clk); #1;
    chk("rst_after", 0, 32'(act), 32'(quiet(3'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
